jk_input_conditioner: RTL and testbench

JK_INPUT_CONDITIONER -- requirements
Module: jk_input_conditioner

---
 rtl/jk_input_conditioner.sv | 105 ++++++++++
 tb/tb_jk_input_conditioner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/jk_input_conditioner.sv
// Synchronizes and debounces two raw switch inputs into a registered {J,K} code for a JK flip-flop.
// Define JK_PULSE_MODE_EN for press-to-pulse output aligned to divider ticks; default is level mode.
module jk_input_conditioner #(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DEB_COUNT = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       j_raw,
  input  logic       k_raw,
  output logic [1:0] jk,
  output logic       jk_chg,
  output logic       tick,
  output logic       dclk
);

  localparam int unsigned CntW = $clog2(DEB_COUNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_COUNT - 1);

  logic [1:0]           raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d;
  logic [CntW-1:0]      cnt_q [2];
  logic [CntW-1:0]      cnt_d [2];
  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick_d, tick_q;
  logic [1:0]           jk_q, jk_d;
  logic                 jk_chg_q;

  assign raw = {j_raw, k_raw};

  // Index 1 is J, index 0 is K; the two paths share no state.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign tick_d = &div_q;

`ifdef JK_PULSE_MODE_EN
  logic [1:0] pend_q, pend_d, rise;

  // Rises accepted on the tick edge itself go straight to jk rather than waiting a period.
  always_comb begin
    rise   = stable_d & ~stable_q;
    pend_d = pend_q | rise;
    jk_d   = jk_q;
    if (tick_d) begin
      jk_d   = pend_q | rise;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  always_comb begin
    jk_d = stable_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      div_q    <= '0;
      tick_q   <= 1'b0;
      jk_q     <= '0;
      jk_chg_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      div_q    <= div_q + 1'b1;
      tick_q   <= tick_d;
      jk_q     <= jk_d;
      jk_chg_q <= (jk_d != jk_q);
    end
  end

  assign jk     = jk_q;
  assign jk_chg = jk_chg_q;
  assign tick   = tick_q;
  assign dclk   = div_q[DIV_WIDTH-1];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Scoreboard bench for jk_input_conditioner in level mode with DIV_WIDTH=4, DEB_COUNT=4.
module tb_jk_input_conditioner;

  localparam int Lat = 7;  // DEB_COUNT + 3 edges from raw change to jk

  logic       clk;
  logic       rst;
  logic       j_raw;
  logic       k_raw;
  logic [1:0] jk;
  logic       jk_chg;
  logic       tick;
  logic       dclk;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_chk;
  int   n_pass;
  bit   mon_rst;

  jk_input_conditioner #(
    .DIV_WIDTH(4),
    .DEB_COUNT(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .j_raw (j_raw),
    .k_raw (k_raw),
    .jk    (jk),
    .jk_chg(jk_chg),
    .tick  (tick),
    .dclk  (dclk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int at, input logic [1:0] val);
    exp_t e;
    e.cyc = at;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // cyc counts rising edges since reset release; tick/dclk follow it directly.
  always @(posedge clk) begin
    exp_t e;
    mon_rst = rst;
    #1;
    if (!mon_rst) begin
      cyc = 0;
      check("rst_jk", int'(jk), 0);
      check("rst_jk_chg", int'(jk_chg), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_dclk", int'(dclk), 0);
    end else begin
      cyc++;
      check("tick", int'(tick), int'(cyc % 16 == 0));
      check("dclk", int'(dclk), int'((cyc % 16) >= 8));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("chg_missed_at", cyc, e.cyc);
      end
      if (jk_chg) begin
        if (exp_q.size() == 0) begin
          check("chg_unexpected_pending", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("chg_cycle", cyc, e.cyc);
          check("jk_value", int'(jk), int'(e.val));
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    rst    = 1'b0;
    j_raw  = 1'b0;
    k_raw  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle: tick and dclk cadence only.
    repeat (40) @(negedge clk);

    // J then K rise.
    j_raw = 1'b1;
    push(cyc + Lat, 2'b10);
    repeat (12) @(negedge clk);
    k_raw = 1'b1;
    push(cyc + Lat, 2'b11);
    repeat (12) @(negedge clk);

    // Both fall together.
    j_raw = 1'b0;
    k_raw = 1'b0;
    push(cyc + Lat, 2'b00);
    repeat (12) @(negedge clk);

    // Bounce: 3 high, 2 low, then held high.
    j_raw = 1'b1;
    repeat (3) @(negedge clk);
    j_raw = 1'b0;
    repeat (2) @(negedge clk);
    j_raw = 1'b1;
    push(cyc + Lat, 2'b10);
    repeat (12) @(negedge clk);
    j_raw = 1'b0;
    push(cyc + Lat, 2'b00);
    repeat (12) @(negedge clk);

    // Simultaneous rise: one step, one pulse.
    j_raw = 1'b1;
    k_raw = 1'b1;
    push(cyc + Lat, 2'b11);
    repeat (12) @(negedge clk);
    j_raw = 1'b0;
    k_raw = 1'b0;
    push(cyc + Lat, 2'b00);
    repeat (12) @(negedge clk);

    // Reset while J count is 2; acceptance must restart from release.
    j_raw = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(Lat, 2'b10);
    repeat (14) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
